// File: rtl/fir_mc_axis.sv
// Time-multiplexed multi-channel FIR with a serial MAC and AXI-Stream ports.
// One sample is in flight at a time; results are rounded half-up, saturated and tagged with their channel.
module fir_mc_axis #(
  parameter int DATA_W    = 12,
  parameter int DATA_FRAC = 11,
  parameter int COEF_W    = 12,
  parameter int COEF_FRAC = 11,
  parameter int OUT_W     = 16,
  parameter int OUT_FRAC  = 14,
  parameter int TAPS      = 16,
  parameter int CHANNELS  = 2,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TA_W     = $clog2(TAPS),
  localparam int ACC_W    = DATA_W + COEF_W + TA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [CH_W-1:0]   s_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [OUT_W-1:0]  m_axis_tdata,
  output logic [CH_W-1:0]   m_axis_tuser,
  output logic              m_sat,
  input  logic              coef_wr_en,
  input  logic [TA_W-1:0]   coef_wr_addr,
  input  logic [COEF_W-1:0] coef_wr_data,
  output logic              busy,
  output logic              err_chan
);

  localparam int SHIFT = DATA_FRAC + COEF_FRAC - OUT_FRAC;
  localparam int RND_W = ACC_W + 1;
  localparam int R_W   = RND_W - SHIFT;
  localparam logic [TA_W-1:0]        TAPS_M1  = TA_W'(TAPS - 1);
  localparam logic [TA_W-1:0]        TA_ONE   = TA_W'(1);
  localparam logic [TA_W:0]          TAPS_L   = TAPS[TA_W:0];
  localparam logic [CH_W:0]          CH_LIM   = CHANNELS[CH_W:0];
  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1) <<< (SHIFT - 1);
  localparam logic signed [R_W-1:0]  R_MAX    = R_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [R_W-1:0]  R_MIN    = R_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [DATA_W-1:0] r_hist [CHANNELS][TAPS];
  logic [TA_W-1:0]          r_wr_ptr [CHANNELS];
  logic signed [COEF_W-1:0] r_coef [TAPS];

  logic [CH_W-1:0]         r_ch;
  logic [TA_W-1:0]         r_p;
  logic [TA_W-1:0]         r_k;
  logic signed [ACC_W-1:0] r_acc;

  logic              r_s_tready;
  logic              r_m_tvalid;
  logic [OUT_W-1:0]  r_m_tdata;
  logic [CH_W-1:0]   r_m_tuser;
  logic              r_m_sat;
  logic              r_busy;
  logic              r_err_chan;

  logic                             w_accept;
  logic                             w_ch_ok;
  logic [TA_W-1:0]                  w_cur_ptr;
  logic [TA_W-1:0]                  w_new_p;
  logic [TA_W:0]                    w_wrap_idx;
  logic [TA_W-1:0]                  w_tap_idx;
  logic signed [DATA_W+COEF_W-1:0]  w_prod;
  logic signed [RND_W-1:0]          w_rnd;
  logic signed [R_W-1:0]            w_r;
  logic [OUT_W-1:0]                 w_out;
  logic                             w_sat;

  assign w_accept   = s_axis_tvalid && r_s_tready && (r_state == ST_IDLE);
  assign w_ch_ok    = ({1'b0, s_axis_tuser} < CH_LIM);
  assign w_cur_ptr  = r_wr_ptr[s_axis_tuser];
  assign w_new_p    = (w_cur_ptr == TAPS_M1) ? {TA_W{1'b0}} : w_cur_ptr + TA_ONE;
  // Newest sample sits at r_p; tap k reaches back k slots, wrapping modulo TAPS.
  assign w_wrap_idx = {1'b0, r_p} + TAPS_L - {1'b0, r_k};
  assign w_tap_idx  = (r_p >= r_k) ? (r_p - r_k) : w_wrap_idx[TA_W-1:0];
  assign w_prod     = r_hist[r_ch][w_tap_idx] * r_coef[r_k];
  assign w_rnd      = {r_acc[ACC_W-1], r_acc} + RND_HALF;
  assign w_r        = R_W'(w_rnd >>> SHIFT);

  // Clamp the rounded accumulator into the output range.
  always_comb begin
    w_sat = 1'b0;
    w_out = w_r[OUT_W-1:0];
    if (w_r > R_MAX) begin
      w_sat = 1'b1;
      w_out = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_r < R_MIN) begin
      w_sat = 1'b1;
      w_out = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      w_sat = 1'b0;
      w_out = w_r[OUT_W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && w_ch_ok) w_state_nxt = ST_MAC;   else w_state_nxt = ST_IDLE;
      ST_MAC:   if (r_k == TAPS_M1)      w_state_nxt = ST_ROUND; else w_state_nxt = ST_MAC;
      ST_ROUND: w_state_nxt = ST_OUT;
      ST_OUT:   if (m_axis_tready)       w_state_nxt = ST_IDLE;  else w_state_nxt = ST_OUT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, storage and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ch       <= {CH_W{1'b0}};
      r_p        <= {TA_W{1'b0}};
      r_k        <= {TA_W{1'b0}};
      r_acc      <= {ACC_W{1'b0}};
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= {OUT_W{1'b0}};
      r_m_tuser  <= {CH_W{1'b0}};
      r_m_sat    <= 1'b0;
      r_busy     <= 1'b0;
      r_err_chan <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_wr_ptr[c] <= {TA_W{1'b0}};
        for (int t = 0; t < TAPS; t++) r_hist[c][t] <= {DATA_W{1'b0}};
      end
      for (int t = 0; t < TAPS; t++) r_coef[t] <= {COEF_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_s_tready <= (w_state_nxt == ST_IDLE);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_err_chan <= w_accept && !w_ch_ok;
      // Writes outside IDLE are dropped so an in-flight result always sees one coefficient set.
      if ((r_state == ST_IDLE) && coef_wr_en) r_coef[coef_wr_addr] <= coef_wr_data;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_ch_ok) begin
            r_hist[s_axis_tuser][w_new_p] <= s_axis_tdata;
            r_wr_ptr[s_axis_tuser]        <= w_new_p;
            r_ch  <= s_axis_tuser;
            r_p   <= w_new_p;
            r_acc <= {ACC_W{1'b0}};
            r_k   <= {TA_W{1'b0}};
          end
        end
        ST_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_k   <= r_k + TA_ONE;
        end
        ST_ROUND: begin
          r_m_tdata  <= w_out;
          r_m_tuser  <= r_ch;
          r_m_sat    <= w_sat;
          r_m_tvalid <= 1'b1;
        end
        ST_OUT: begin
          if (m_axis_tready) r_m_tvalid <= 1'b0;
        end
        default: r_m_tvalid <= 1'b0;
      endcase
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tuser  = r_m_tuser;
  assign m_sat         = r_m_sat;
  assign busy          = r_busy;
  assign err_chan      = r_err_chan;

endmodule

// File: tb/tb_fir_mc_axis.sv
// Directed bench for fir_mc_axis: impulse, channel isolation, saturation, rounding,
// backpressure with ignored coefficient write, bad channel (3-channel instance) and mid-MAC reset.
module tb_fir_mc_axis;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s_tvalid, s_tready;
  logic [11:0] s_tdata;
  logic [0:0]  s_tuser;
  logic        m_tvalid, m_tready;
  logic [15:0] m_tdata;
  logic [0:0]  m_tuser;
  logic        m_sat;
  logic        coef_en;
  logic [3:0]  coef_addr;
  logic [11:0] coef_data;
  logic        busy, err;

  logic        s3_tvalid, s3_tready;
  logic [11:0] s3_tdata;
  logic [1:0]  s3_tuser;
  logic        m3_tvalid;
  logic [15:0] m3_tdata;
  logic [1:0]  m3_tuser;
  logic        m3_sat, busy3, err3;

  fir_mc_axis u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser),
    .m_sat(m_sat), .coef_wr_en(coef_en), .coef_wr_addr(coef_addr), .coef_wr_data(coef_data),
    .busy(busy), .err_chan(err)
  );

  fir_mc_axis #(.CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s3_tvalid), .s_axis_tready(s3_tready), .s_axis_tdata(s3_tdata), .s_axis_tuser(s3_tuser),
    .m_axis_tvalid(m3_tvalid), .m_axis_tready(1'b1), .m_axis_tdata(m3_tdata), .m_axis_tuser(m3_tuser),
    .m_sat(m3_sat), .coef_wr_en(1'b0), .coef_wr_addr(4'd0), .coef_wr_data(12'd0),
    .busy(busy3), .err_chan(err3)
  );

  int n_vec = 0;
  int n_bad = 0;
  int lat;
  logic [15:0] y, y0;
  logic        sat, sat0;
  logic [0:0]  usr, usr0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [0:0] ch, input logic [11:0] d);
    int n = 0;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) check_val("push_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = ch;
    @(posedge clk);
    #1 s_tvalid = 1'b0;
  endtask

  // Counts edges after the accepting edge until the result is visible.
  task automatic wait_out();
    lat = 0;
    while (!m_tvalid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!m_tvalid) check_val("out_timeout", 32'd0, 32'd1);
    y   = m_tdata;
    sat = m_sat;
    usr = m_tuser;
  endtask

  task automatic xfer(input logic [0:0] ch, input logic [11:0] d);
    push(ch, d);
    wait_out();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [11:0] d);
    @(negedge clk);
    coef_en   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk);
    #1 coef_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rin [4];
    logic [15:0] rexp [4];
    int seen;
    rin  = '{12'd128, 12'd127, 12'hF80, 12'hF7F};
    rexp = '{16'd1, 16'd0, 16'd0, 16'hFFFF};

    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 12'd0; s_tuser = 1'b0;
    m_tready = 1'b1; coef_en = 1'b0; coef_addr = 4'd0; coef_data = 12'd0;
    s3_tvalid = 1'b0; s3_tdata = 12'd0; s3_tuser = 2'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tready", {31'd0, s_tready}, 32'd0);
    check_val("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check_val("rst_busy_err", {30'd0, busy, err}, 32'd0);
    check_val("rst_out", {15'd0, m_tdata, m_tuser, m_sat}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check_val("rel_tready", {31'd0, s_tready}, 32'd1);

    // Impulse response with h[k] = k+1: outputs 4, 8, ... 64
    for (int k = 0; k < 16; k++) write_coef(4'(k), 12'(k + 1));
    push(1'b0, 12'd1024);
    check_val("acc_tready", {31'd0, s_tready}, 32'd0);
    check_val("acc_busy", {31'd0, busy}, 32'd1);
    wait_out();
    check_val("latency", lat, 32'd17);
    @(posedge clk);
    #1;
    check_val("imp_y0", {16'd0, y}, 32'd4);
    check_val("imp_us0", {30'd0, usr, sat}, 32'd0);
    check_val("ret_tready", {31'd0, s_tready}, 32'd1);
    for (int n = 1; n < 16; n++) begin
      xfer(1'b0, 12'd0);
      check_val("imp_y", {16'd0, y}, 32'(4 * (n + 1)));
      check_val("imp_us", {30'd0, usr, sat}, 32'd0);
    end

    // Channel isolation: ch0 step, ch1 zeros
    for (int n = 0; n < 16; n++) begin
      xfer(1'b0, 12'd1024);
      check_val("iso_ch0", {16'd0, y}, 32'(2 * (n + 1) * (n + 2)));
      check_val("iso_u0", {31'd0, usr}, 32'd0);
      xfer(1'b1, 12'd0);
      check_val("iso_ch1", {16'd0, y}, 32'd0);
      check_val("iso_u1", {31'd0, usr}, 32'd1);
    end

    // Saturation with all h = 0x7FF
    for (int k = 0; k < 16; k++) write_coef(4'(k), 12'h7FF);
    for (int n = 0; n < 16; n++) xfer(1'b0, 12'h7FF);
    check_val("sat_pos", {16'd0, y}, 32'h7FFF);
    check_val("sat_pos_f", {31'd0, sat}, 32'd1);
    for (int n = 0; n < 16; n++) xfer(1'b0, 12'h800);
    check_val("sat_neg", {16'd0, y}, 32'h8000);
    check_val("sat_neg_f", {31'd0, sat}, 32'd1);

    // Rounding with h[0] = 1 only
    write_coef(4'd0, 12'd1);
    for (int k = 1; k < 16; k++) write_coef(4'(k), 12'd0);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, rin[i]);
      check_val("round", {16'd0, y}, {16'd0, rexp[i]});
      check_val("round_sat", {31'd0, sat}, 32'd0);
    end

    // Backpressure: output held, input blocked, coefficient write ignored
    m_tready = 1'b0;
    push(1'b1, 12'd256);
    wait_out();
    y0 = y; sat0 = sat; usr0 = usr;
    check_val("bp_y", {16'd0, y0}, 32'd1);
    check_val("bp_u", {31'd0, usr0}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) begin
        coef_en = 1'b1; coef_addr = 4'd0; coef_data = 12'h400;
      end else begin
        coef_en = 1'b0;
      end
      check_val("bp_hold", {15'd0, m_tdata, m_tuser, m_sat}, {15'd0, y0, usr0, sat0});
      check_val("bp_flags", {29'd0, s_tready, m_tvalid, busy}, 32'd3);
    end
    m_tready = 1'b1;
    @(posedge clk);
    #1 check_val("bp_release", {31'd0, m_tvalid}, 32'd0);
    xfer(1'b1, 12'd256);
    check_val("bp_coef_kept", {16'd0, y}, 32'd1);

    // Bad channel on the three-channel instance
    @(negedge clk);
    s3_tvalid = 1'b1; s3_tuser = 2'd3; s3_tdata = 12'd100;
    @(posedge clk);
    #1 s3_tvalid = 1'b0;
    check_val("err_pulse", {31'd0, err3}, 32'd1);
    @(posedge clk);
    #1 check_val("err_clear", {31'd0, err3}, 32'd0);
    check_val("err_idle", {30'd0, s3_tready, busy3}, 32'd2);
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (m3_tvalid) seen++;
    end
    check_val("err_noout", seen, 32'd0);
    check_val("main_no_err", {31'd0, err}, 32'd0);

    // Reset mid-MAC clears history and coefficients
    for (int k = 0; k < 16; k++) write_coef(4'(k), 12'(k + 1));
    push(1'b0, 12'd1024);
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1 check_val("mrst_state", {30'd0, busy, m_tvalid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check_val("mrst_tready", {31'd0, s_tready}, 32'd1);
    for (int n = 0; n < 16; n++) begin
      xfer(1'b0, (n == 0) ? 12'd1024 : 12'd0);
      check_val("mrst_imp", {15'd0, y, sat}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_mc_axis.md
# fir_mc_axis

Time-multiplexed, multi-channel FIR filter with AXI-Stream in/out and a runtime-writable coefficient bank. It replaces the fixed 16-tap band-pass stage in the sample path. The generalisations are parametrised taps and channels, per-channel history, a serial MAC with correct backpressure, round-half-up with saturation, and a channel tag carried in TUSER.

## Interface
- DATA_W, 12: input sample width, signed.
- DATA_FRAC, 11: input fractional bits.
- COEF_W, 12: coefficient width, signed.
- COEF_FRAC, 11: coefficient fractional bits.
- OUT_W, 16: output width, signed.
- OUT_FRAC, 14: output fractional bits. Requires SHIFT = DATA_FRAC+COEF_FRAC-OUT_FRAC ≥ 1.
- TAPS, 16: tap count, ≥ 2.
- CHANNELS, 2: independent channels, ≥ 1.
- Derived: CH_W = max(1, clog2(CHANNELS)); TA_W = clog2(TAPS); ACC_W = DATA_W+COEF_W+TA_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  DATA_W  input sample.
- s_axis_tuser  in  CH_W  channel index.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tdata  out  OUT_W  filtered sample.
- m_axis_tuser  out  CH_W  channel of the output.
- m_sat  out  1  output was saturated; qualified by m_axis_tvalid.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  TA_W  tap index k.
- coef_wr_data  in  COEF_W  h[k].
- busy  out  1  state ≠ IDLE.
- err_chan  out  1  one-cycle pulse when a sample with tuser ≥ CHANNELS is accepted.

## Operation
- Storage:
  - History: CHANNELS×TAPS registers, each DATA_W wide.
  - Pointers: one write pointer wr_ptr[ch] per channel, mod TAPS.
  - Coefficients: TAPS registers.
- Reset clears all storage and all pointers to 0.
- FSM states: IDLE, MAC, ROUND, OUT.
- IDLE:
  - s_axis_tready = 1.
  - On handshake with a valid channel c:
    - Write the sample to slot p = wr_ptr[c]+1 (mod TAPS) and set wr_ptr[c] ← p.
    - Latch c, set acc ← 0 and k ← 0, go to MAC.
  - On handshake with tuser ≥ CHANNELS: drop the sample, pulse err_chan, stay in IDLE.
- MAC:
  - Each cycle, acc += x[c][(p−k) mod TAPS] × h[k], then k++.
  - After the k = TAPS−1 update, go to ROUND.
  - acc is ACC_W wide and signed; it cannot overflow.
- ROUND:
  - r = (acc + 2^(SHIFT−1)) >>> SHIFT, arithmetic shift (round half up).
  - If r > 2^(OUT_W−1)−1 or r < −2^(OUT_W−1): clamp r and set m_sat = 1; otherwise m_sat = 0.
  - Load m_axis_tdata, m_axis_tuser and m_sat; set m_axis_tvalid = 1; go to OUT.
- OUT:
  - Hold m_axis_tdata, m_axis_tuser and m_sat stable.
  - On m_axis_tvalid && m_axis_tready: clear m_axis_tvalid, go to IDLE.
- s_axis_tready is 0 in MAC, ROUND and OUT.
- Coefficient writes:
  - Take effect only in IDLE: h[coef_wr_addr] ← coef_wr_data at the edge.
  - Ignored, not queued, in all other states, so in-flight results are never corrupted.
  - If a coefficient write and a sample handshake occur on the same IDLE edge, both take effect; the new coefficient is used by that sample's MAC.
- Reset values: s_axis_tready 0 while rst_n = 0, then 1 on the first cycle after release. m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_sat, busy and err_chan all 0.
- Reset asserted mid-operation: the in-flight result is discarded and all state and outputs take reset values at that edge.

## Timing
- Input accepted at edge E0:
  - MAC updates occur at edges E1..E_TAPS.
  - ROUND loads the output at edge E_TAPS+1, so m_axis_tvalid is high from E_TAPS+1.
- With m_axis_tready held high:
  - The output handshake is at E_TAPS+2.
  - s_axis_tready is high again after E_TAPS+2.
  - The next accept is no earlier than E_TAPS+3, giving one sample per TAPS+3 cycles (19 at defaults).
- Backpressure stalls only OUT; there is no output buffering beyond one entry.
- Outputs leave in the same order as inputs, each tagged with its input channel.

## Test plan
- Impulse response (defaults): write h[k] = k+1, then send ch0 sample 1024 (0.5) followed by 15 zeros.
  -> m_axis_tdata = 4, 8, …, 64; tuser = 0; m_sat = 0.
- Channel isolation: send ch0 constant 1024 interleaved with ch1 zeros, h[k] = k+1.
  -> ch0 outputs 4, 12, 24, 40, …, 544 (steady); ch1 outputs all 0 with tuser = 1.
- Saturation: all h = 0x7FF.
  - Sixteen ch0 samples of 0x7FF -> last output 0x7FFF with m_sat = 1.
  - Sixteen samples of 0x800 -> last output 0x8000 with m_sat = 1.
- Rounding: h[0] = 1, other taps 0. Inputs 128, 127, −128, −129 -> outputs 1, 0, 0, −1.
- Backpressure, coefficients and bad channel:
  - Hold m_axis_tready low 10 cycles in OUT -> tdata, tuser and m_sat stable; s_axis_tready = 0; a coefficient write issued then has no effect.
  - A sample with tuser = CHANNELS -> err_chan pulses for 1 cycle and no output is produced.
- Reset mid-MAC: drive rst_n low for 1 cycle at E5.
  -> next cycle busy = 0, m_axis_tvalid = 0, s_axis_tready = 1; the next impulse response shows cleared history and zeroed coefficients (all outputs 0).
